reg_bank_seq: RTL and testbench
===============================

Name: reg_bank_seq

Overview:
- Sequencer that drives the strobe side of the 4x8 register bank (sel/en/load/reset) on behalf of the control path.
- Accepts one register-access command at a time over a valid/ready handshake and expands it into correctly timed bank strobes.
- Supported commands: read, write-immediate, move and swap.
- Reports completion with a one-cycle done pulse and read data.
- Sits between the instruction decoder and the register bank; it is the only driver of the bank's strobe inputs.

Parameters:
- DATA_W, 8, bank word width.
- ADDR_W, 2, register select width (2^ADDR_W registers).
- RD_LAT, 1, cycles between bank_en high and the bank_rdata sample point; legal range 1..3.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  0=RD, 1=WR, 2=MOV, 3=SWAP.
- cmd_rs  input  ADDR_W  source register.
- cmd_rd  input  ADDR_W  destination register.
- cmd_imm  input  DATA_W  immediate for WR.
- done  output  1  one-cycle completion pulse.
- rsp_data  output  DATA_W  RD result; valid with done.
- bank_sel  output  ADDR_W  to bank sel.
- bank_en  output  1  to bank en (read strobe).
- bank_load  output  1  to bank load (write strobe).
- bank_reset  output  1  to bank reset (clear all).
- bank_wdata  output  DATA_W  to bank in.
- bank_rdata  input  DATA_W  from bank out.

Behaviour:
- Reset values (reset_n low): state INIT; cmd_ready, done, bank_en, bank_load and bank_reset all 0; bank_sel, bank_wdata and rsp_data all 0.
- All outputs are registered.
- INIT: on the first clock after reset_n releases, bank_reset=1 for exactly one cycle, then the state goes to IDLE. cmd_ready stays 0 during INIT.
- IDLE: cmd_ready=1. A command is accepted on a cycle where cmd_valid & cmd_ready; op, rs, rd and imm are latched at that point. cmd_ready is 0 from the cycle after acceptance until the state returns to IDLE.
- Bank access primitive:
  - SETUP cycle: bank_sel (and bank_wdata for writes) driven, strobes low.
  - STROBE cycle: bank_en or bank_load =1; sel and wdata unchanged.
  - For reads, RD_LAT further cycles with strobes low and sel held. bank_rdata is captured into a temp register at the end of the last of these cycles.
  - bank_en, bank_load and bank_reset are never high in the same cycle.
- Sequences:
  - RD: read rs; rsp_data <= captured value.
  - WR: write cmd_imm to rd.
  - MOV: read rs into tmpA; write tmpA to rd.
  - SWAP: read rs into tmpA; read rd into tmpB; write tmpA to rd; write tmpB to rs.
- States: INIT, IDLE, RD_SETUP, RD_STROBE, RD_WAIT (counter 0..RD_LAT-1), WR_SETUP, WR_STROBE, DONE. A phase flag selects the first or second read/write for SWAP.
- Latency from the acceptance cycle to the done cycle:
  - RD = 3+RD_LAT
  - WR = 3
  - MOV = 5+RD_LAT
  - SWAP = 9+2*RD_LAT
- DONE: done=1 for one cycle, then IDLE. cmd_ready rises the cycle after done.
- rsp_data updates only on RD and otherwise holds its previous value.
- rs==rd: full sequence executes unchanged; the register value is unchanged afterwards.
- cmd_op fields are decoded only at acceptance. Input changes mid-operation are ignored.
- reset_n asserted mid-operation: immediate return to reset values. Bank content for the aborted command is unspecified. The INIT clear then zeroes the bank.

Decomposition:
- Shared package: op encodings (OP_RD, OP_WR, OP_MOV, OP_SWAP), state encoding, DATA_W/ADDR_W defaults.
- One natural sub-module, reg_bank_access: a single SETUP/STROBE/WAIT access engine (start, is_write, sel, wdata -> busy, rdata_valid, rdata) instantiated once. The top FSM sequences it.

Test Plan:
- Reset release -> bank_reset high exactly one cycle, then cmd_ready=1. A subsequent RD of every register returns 8'h00.
- WR rd=2 imm=8'hA5, then RD rs=2 -> WR done 3 cycles after accept. RD done 4 cycles after accept (RD_LAT=1) with rsp_data=8'hA5.
- Regs r0=8'h11, r3=8'h3C; MOV rs=3 rd=0 -> done at accept+6; RD r0 returns 8'h3C; r3 still 8'h3C.
- r1=8'h5A, r2=8'hC3; SWAP rs=1 rd=2 -> done at accept+11. Then r1=8'hC3, r2=8'h5A. Strobe order: en(r1), en(r2), load(r2), load(r1).
- cmd_valid held high across back-to-back commands -> exactly one acceptance per IDLE visit; no strobe ever coincides with a sel change; en, load and reset are never simultaneously high.
- reset_n pulsed low during the second read of a SWAP -> all outputs immediately at reset values, INIT clear pulse follows, and the next command executes normally.

Source files
------------

// File: rtl/reg_bank_seq_pkg.sv
// reg_bank_seq_pkg
// Shared definitions for the register-bank sequencer:
//   - default bank geometry and read latency
//   - command opcode encoding (op_t)
//   - top-level sequencer states (seq_state_t)
//   - access-engine states (acc_state_t)
//   - op_reads_first(): true when a command starts with a bank read
package reg_bank_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int RD_LAT_DEF = 1;
  localparam int OP_W       = 2;
  // Wide enough for the wait counter at the largest supported RD_LAT (3).
  localparam int CNT_W      = 2;

  typedef enum logic [OP_W-1:0] {
    OP_RD   = 2'd0,
    OP_WR   = 2'd1,
    OP_MOV  = 2'd2,
    OP_SWAP = 2'd3
  } op_t;

  // The top FSM only tracks which kind of access is in flight; the
  // SETUP/STROBE/WAIT timing of each access lives in the access engine.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ACC_IDLE   = 2'd0,
    ACC_SETUP  = 2'd1,
    ACC_STROBE = 2'd2,
    ACC_WAIT   = 2'd3
  } acc_state_t;

  function automatic logic op_reads_first(op_t op);
    return (op != OP_WR);
  endfunction

endpackage

// File: rtl/reg_bank_seq_if.sv
// reg_bank_seq_if
// Command channel between the instruction decoder (master) and the
// register-bank sequencer (slave).
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/rs/rd/imm    : command fields, sampled on acceptance
//   done                : one-cycle completion pulse
//   rsp_data            : read result, valid with done
interface reg_bank_seq_if
  import reg_bank_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_rs;
  logic [ADDR_W-1:0] cmd_rd;
  logic [DATA_W-1:0] cmd_imm;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rd, cmd_imm,
    input  cmd_ready, done, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rd, cmd_imm,
    output cmd_ready, done, rsp_data
  );

endinterface

// File: rtl/reg_bank_seq_access.sv
// reg_bank_seq_access
// Single bank access engine. One start request produces
//   SETUP  : bank_sel (and bank_wdata for writes) driven, strobes low
//   STROBE : bank_en (read) or bank_load (write) high
//   WAIT   : RD_LAT cycles, reads only, strobes low, sel held
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start, is_write         request a new access (taken when !busy)
//   sel, wdata              register select / write data for the request
//   busy                    a start would be ignored this cycle
//   rdata_valid, rdata      last WAIT cycle of a read; rdata is bank_rdata
//   bank_sel/en/load/wdata  registered bank strobe outputs
//   bank_rdata              bank read data
module reg_bank_seq_access
  import reg_bank_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bank_sel,
  output logic              bank_en,
  output logic              bank_load,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);

  acc_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wr_q, wr_nxt;
  logic [ADDR_W-1:0] sel_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              en_nxt, load_nxt;
  logic              last_rd;

  assign last_rd     = (state == ACC_WAIT) && (cnt == CNT_W'(RD_LAT - 1));
  assign rdata_valid = last_rd;
  assign rdata       = bank_rdata;

  // The final cycle of an access (write STROBE, last read WAIT) is not busy,
  // so the next access can start there and run back-to-back with no gap.
  assign busy = (state == ACC_SETUP) ||
                ((state == ACC_STROBE) && !wr_q) ||
                ((state == ACC_WAIT) && !last_rd);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr_q;
    sel_nxt   = bank_sel;
    wdata_nxt = bank_wdata;
    en_nxt    = 1'b0;
    load_nxt  = 1'b0;

    case (state)
      ACC_IDLE: ;
      ACC_SETUP: begin
        state_nxt = ACC_STROBE;
        en_nxt    = !wr_q;
        load_nxt  = wr_q;
      end
      ACC_STROBE: begin
        if (wr_q) begin
          state_nxt = ACC_IDLE;
        end else begin
          state_nxt = ACC_WAIT;
          cnt_nxt   = '0;
        end
      end
      ACC_WAIT: begin
        if (last_rd) state_nxt = ACC_IDLE;
        else         cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ACC_IDLE;
    endcase

    // sel and wdata only ever change on entry to SETUP, where the strobes
    // are low, so no strobe can coincide with a select change.
    if (start && !busy) begin
      state_nxt = ACC_SETUP;
      wr_nxt    = is_write;
      sel_nxt   = sel;
      if (is_write) wdata_nxt = wdata;
      en_nxt    = 1'b0;
      load_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ACC_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      bank_sel   <= '0;
      bank_wdata <= '0;
      bank_en    <= 1'b0;
      bank_load  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wr_q       <= wr_nxt;
      bank_sel   <= sel_nxt;
      bank_wdata <= wdata_nxt;
      bank_en    <= en_nxt;
      bank_load  <= load_nxt;
    end
  end

endmodule

// File: rtl/reg_bank_seq.sv
// reg_bank_seq
// Sequencer that owns the strobe side of the 4x8 register bank. After reset
// it clears the bank once, then accepts one command at a time (RD, WR, MOV,
// SWAP) and expands it into reads/writes through reg_bank_seq_access.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   cmd                      command channel (slave side): handshake,
//                            op/rs/rd/imm, done pulse and rsp_data
//   bank_sel/en/load/reset   registered bank strobes
//   bank_wdata, bank_rdata   bank data in / out
module reg_bank_seq
  import reg_bank_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  reg_bank_seq_if.slave     cmd,
  output logic [ADDR_W-1:0] bank_sel,
  output logic              bank_en,
  output logic              bank_load,
  output logic              bank_reset,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);

  seq_state_t        state, state_nxt;
  logic              phase, phase_nxt;
  op_t               op_q, op_nxt;
  logic [ADDR_W-1:0] rs_q, rs_nxt;
  logic [ADDR_W-1:0] rd_q, rd_nxt;
  logic [DATA_W-1:0] tmp_a, tmp_a_nxt;
  logic [DATA_W-1:0] tmp_b, tmp_b_nxt;
  logic [DATA_W-1:0] rsp_q, rsp_nxt;
  logic              ready_q, ready_nxt;
  logic              done_q, done_nxt;
  logic              clr_q, clr_nxt;

  logic              acc_start;
  logic              acc_is_write;
  logic [ADDR_W-1:0] acc_sel;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_busy;
  logic              acc_rdata_valid;
  logic [DATA_W-1:0] acc_rdata;

  logic              accept;
  op_t               cmd_op_dec;

  assign accept        = cmd.cmd_valid && ready_q;
  assign cmd_op_dec    = op_t'(cmd.cmd_op);
  assign cmd.cmd_ready = ready_q;
  assign cmd.done      = done_q;
  assign cmd.rsp_data  = rsp_q;
  assign bank_reset    = clr_q;

  reg_bank_seq_access #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_access (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (acc_start),
    .is_write    (acc_is_write),
    .sel         (acc_sel),
    .wdata       (acc_wdata),
    .busy        (acc_busy),
    .rdata_valid (acc_rdata_valid),
    .rdata       (acc_rdata),
    .bank_sel    (bank_sel),
    .bank_en     (bank_en),
    .bank_load   (bank_load),
    .bank_wdata  (bank_wdata),
    .bank_rdata  (bank_rdata)
  );

  // Next-state / next-output logic. Every access is launched in the same
  // cycle the previous one finishes, so the first access of a command starts
  // straight from the raw cmd fields at acceptance, and read results feed
  // the next write directly rather than waiting for tmp_a to settle.
  // phase picks the first or second read/write of a SWAP.
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    op_nxt       = op_q;
    rs_nxt       = rs_q;
    rd_nxt       = rd_q;
    tmp_a_nxt    = tmp_a;
    tmp_b_nxt    = tmp_b;
    rsp_nxt      = rsp_q;
    ready_nxt    = ready_q;
    done_nxt     = 1'b0;
    clr_nxt      = 1'b0;
    acc_start    = 1'b0;
    acc_is_write = 1'b0;
    acc_sel      = rs_q;
    acc_wdata    = tmp_a;

    case (state)
      // clr_q doubles as the "clear already issued" marker.
      ST_INIT: begin
        if (!clr_q) begin
          clr_nxt = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          ready_nxt = 1'b0;
          op_nxt    = cmd_op_dec;
          rs_nxt    = cmd.cmd_rs;
          rd_nxt    = cmd.cmd_rd;
          phase_nxt = 1'b0;
          acc_start = 1'b1;
          if (op_reads_first(cmd_op_dec)) begin
            acc_sel   = cmd.cmd_rs;
            state_nxt = ST_READ;
          end else begin
            acc_is_write = 1'b1;
            acc_sel      = cmd.cmd_rd;
            acc_wdata    = cmd.cmd_imm;
            state_nxt    = ST_WRITE;
          end
        end
      end

      ST_READ: begin
        if (acc_rdata_valid) begin
          case (op_q)
            OP_MOV: begin
              tmp_a_nxt    = acc_rdata;
              acc_start    = 1'b1;
              acc_is_write = 1'b1;
              acc_sel      = rd_q;
              acc_wdata    = acc_rdata;
              state_nxt    = ST_WRITE;
            end
            OP_SWAP: begin
              acc_start = 1'b1;
              if (!phase) begin
                tmp_a_nxt = acc_rdata;
                acc_sel   = rd_q;
                phase_nxt = 1'b1;
              end else begin
                tmp_b_nxt    = acc_rdata;
                acc_is_write = 1'b1;
                acc_sel      = rd_q;
                acc_wdata    = tmp_a;
                phase_nxt    = 1'b0;
                state_nxt    = ST_WRITE;
              end
            end
            default: begin
              rsp_nxt   = acc_rdata;
              done_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end
          endcase
        end
      end

      ST_WRITE: begin
        if (!acc_busy) begin
          if ((op_q == OP_SWAP) && !phase) begin
            acc_start    = 1'b1;
            acc_is_write = 1'b1;
            acc_sel      = rs_q;
            acc_wdata    = tmp_b;
            phase_nxt    = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        ready_nxt = 1'b1;
      end

      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      phase   <= 1'b0;
      op_q    <= OP_RD;
      rs_q    <= '0;
      rd_q    <= '0;
      tmp_a   <= '0;
      tmp_b   <= '0;
      rsp_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      op_q    <= op_nxt;
      rs_q    <= rs_nxt;
      rd_q    <= rd_nxt;
      tmp_a   <= tmp_a_nxt;
      tmp_b   <= tmp_b_nxt;
      rsp_q   <= rsp_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      clr_q   <= clr_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq
// Testbench for reg_bank_seq (RD_LAT=1) with a behavioural 4x8 bank model.
module tb_reg_bank_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] bank_sel;
  logic       bank_en;
  logic       bank_load;
  logic       bank_reset;
  logic [7:0] bank_wdata;
  logic [7:0] bank_rdata;

  int checks = 0;
  int failures = 0;
  int violations = 0;
  int reset_cycles = 0;
  logic [1:0] prev_sel = 2'd0;
  logic [2:0] strobe_log [$];

  typedef struct {
    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rd;
    logic [7:0] imm;
    int         lat;
    logic [7:0] rsp;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  reg_bank_seq_if #(.DATA_W(8), .ADDR_W(2)) cmd_if ();

  reg_bank_seq #(.DATA_W(8), .ADDR_W(2), .RD_LAT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (cmd_if),
    .bank_sel   (bank_sel),
    .bank_en    (bank_en),
    .bank_load  (bank_load),
    .bank_reset (bank_reset),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  // Bank model: registered read port with one cycle of latency.
  logic [7:0] bank_regs [4];
  initial begin
    for (int i = 0; i < 4; i++) bank_regs[i] = 8'hEE;
    bank_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (bank_reset) begin
      for (int i = 0; i < 4; i++) bank_regs[i] <= 8'h00;
    end else if (bank_load) begin
      bank_regs[bank_sel] <= bank_wdata;
    end
    if (bank_en) bank_rdata <= bank_regs[bank_sel];
  end

  // Strobe-rule monitor and strobe order log.
  always @(negedge clk) begin
    if (int'(bank_en) + int'(bank_load) + int'(bank_reset) > 1) violations++;
    if ((bank_en || bank_load) && (bank_sel != prev_sel)) violations++;
    if (bank_en)    strobe_log.push_back({1'b0, bank_sel});
    if (bank_load)  strobe_log.push_back({1'b1, bank_sel});
    if (bank_reset) reset_cycles++;
    prev_sel = bank_sel;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, output int lat, output logic [7:0] rsp);
    int n;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_timeout: got cmd_ready=%b, expected 1", cmd_if.cmd_ready);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = v.op;
    cmd_if.cmd_rs    = v.rs;
    cmd_if.cmd_rd    = v.rd;
    cmd_if.cmd_imm   = v.imm;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd3;
    cmd_if.cmd_rs    = ~v.rs;
    cmd_if.cmd_imm   = 8'h99;
    lat = 1;
    while (cmd_if.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    rsp = cmd_if.rsp_data;
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [1:0] rs,
                         input logic [1:0] rd, input logic [7:0] imm,
                         input int exp_lat, input logic [7:0] exp_rsp);
    vec_t v;
    int lat;
    logic [7:0] rsp;
    v = '{op, rs, rd, imm, exp_lat, exp_rsp};
    apply_stimulus(v, lat, rsp);
    check_output({name, "_lat"}, lat, exp_lat);
    check_output({name, "_rsp"}, {24'h0, rsp}, {24'h0, exp_rsp});
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, "_ready_done"}, {30'h0, cmd_if.cmd_ready, cmd_if.done}, 32'h0);
    check_output({name, "_strobes"}, {29'h0, bank_en, bank_load, bank_reset}, 32'h0);
    check_output({name, "_sel_wdata_rsp"}, {14'h0, bank_sel, bank_wdata, cmd_if.rsp_data}, 32'h0);
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values({name, "_held"});
    reset_n = 1'b1;
    @(negedge clk);
    check_output({name, "_clr_pulse"}, {30'h0, bank_reset, cmd_if.cmd_ready}, 32'h2);
    @(negedge clk);
    check_output({name, "_clr_done"}, {30'h0, bank_reset, cmd_if.cmd_ready}, 32'h1);
  endtask

  initial begin
    int n;
    int ready_cnt, done_cnt, load_cnt;
    int lat;
    logic [7:0] rsp;
    logic [11:0] order;

    // op, rs, rd, imm, latency, rsp_data at done
    vecs[0]  = '{2'd0, 2'd0, 2'd3, 8'hFF, 4,  8'h00};
    vecs[1]  = '{2'd0, 2'd1, 2'd2, 8'hFF, 4,  8'h00};
    vecs[2]  = '{2'd0, 2'd2, 2'd1, 8'hFF, 4,  8'h00};
    vecs[3]  = '{2'd0, 2'd3, 2'd0, 8'hFF, 4,  8'h00};
    vecs[4]  = '{2'd1, 2'd0, 2'd2, 8'hA5, 3,  8'h00};
    vecs[5]  = '{2'd0, 2'd2, 2'd0, 8'h00, 4,  8'hA5};
    vecs[6]  = '{2'd1, 2'd3, 2'd0, 8'h11, 3,  8'hA5};
    vecs[7]  = '{2'd1, 2'd1, 2'd3, 8'h3C, 3,  8'hA5};
    vecs[8]  = '{2'd2, 2'd3, 2'd0, 8'h77, 6,  8'hA5};
    vecs[9]  = '{2'd0, 2'd0, 2'd1, 8'h00, 4,  8'h3C};
    vecs[10] = '{2'd0, 2'd3, 2'd3, 8'h00, 4,  8'h3C};
    vecs[11] = '{2'd1, 2'd2, 2'd1, 8'h5A, 3,  8'h3C};
    vecs[12] = '{2'd1, 2'd0, 2'd2, 8'hC3, 3,  8'h3C};
    vecs[13] = '{2'd3, 2'd3, 2'd3, 8'h00, 11, 8'h3C};
    vecs[14] = '{2'd0, 2'd3, 2'd0, 8'h00, 4,  8'h3C};
    vecs[15] = '{2'd2, 2'd1, 2'd1, 8'h00, 6,  8'h3C};
    vecs[16] = '{2'd0, 2'd1, 2'd0, 8'h00, 4,  8'h5A};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_rs    = 2'd0;
    cmd_if.cmd_rd    = 2'd0;
    cmd_if.cmd_imm   = 8'h00;
    #2 reset_n = 1'b0;

    $display("[TB] reset and INIT clear");
    do_reset("init");

    $display("[TB] table vectors");
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i], lat, rsp);
      check_output($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check_output($sformatf("vec%0d_rsp", i), {24'h0, rsp}, {24'h0, vecs[i].rsp});
    end

    $display("[TB] swap r1/r2 with strobe order");
    strobe_log.delete();
    run_cmd("swap12", 2'd3, 2'd1, 2'd2, 8'h00, 11, 8'h5A);
    check_output("swap12_nstrobes", strobe_log.size(), 4);
    order = 12'h0;
    for (int i = 0; i < strobe_log.size() && i < 4; i++) order = {order[8:0], strobe_log[i]};
    check_output("swap12_order", {20'h0, order}, {20'h0, 3'b001, 3'b010, 3'b110, 3'b101});
    run_cmd("swap12_r1", 2'd0, 2'd1, 2'd0, 8'h00, 4, 8'hC3);
    run_cmd("swap12_r2", 2'd0, 2'd2, 2'd0, 8'h00, 4, 8'h5A);

    $display("[TB] cmd_valid held across back-to-back writes");
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("b2b_ready_start", {31'h0, cmd_if.cmd_ready}, 32'h1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd1;
    cmd_if.cmd_rs    = 2'd3;
    cmd_if.cmd_rd    = 2'd0;
    cmd_if.cmd_imm   = 8'h77;
    ready_cnt = 0;
    done_cnt  = 0;
    load_cnt  = 0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_if.cmd_ready === 1'b1) ready_cnt++;
      if (cmd_if.done === 1'b1)      done_cnt++;
      if (bank_load === 1'b1)        load_cnt++;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    check_output("b2b_ready_cycles", ready_cnt, 5);
    check_output("b2b_dones", done_cnt, 5);
    check_output("b2b_loads", load_cnt, 5);
    run_cmd("b2b_r0", 2'd0, 2'd0, 2'd1, 8'h00, 4, 8'h77);

    $display("[TB] reset during second read of swap");
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd3;
    cmd_if.cmd_rs    = 2'd1;
    cmd_if.cmd_rd    = 2'd2;
    cmd_if.cmd_imm   = 8'h00;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_output("abort_second_read_strobe", {29'h0, bank_en, bank_sel}, {29'h0, 1'b1, 2'd2});
    reset_n = 1'b0;
    #1;
    check_reset_values("abort_immediate");
    do_reset("abort");
    run_cmd("abort_r2", 2'd0, 2'd2, 2'd0, 8'h00, 4, 8'h00);
    run_cmd("abort_wr3", 2'd1, 2'd0, 2'd3, 8'h42, 3, 8'h00);
    run_cmd("abort_r3", 2'd0, 2'd3, 2'd0, 8'h00, 4, 8'h42);

    check_output("strobe_rules", violations, 0);
    check_output("clear_pulses", reset_cycles, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
